// File: rtl/raster_fb_capture.sv
// raster_fb_capture: captures rasterizer pixel writes into a 1-bit framebuffer
// and drains it one row per valid/ready transfer once the frame completes.
module raster_fb_capture #(
   parameter int WIDTH = 8,
   parameter int HEIGHT = 8,
   parameter bit BLEND_OR = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      frame_start,
   input  logic                      pix_valid,
   input  logic [$clog2(WIDTH)-1:0]  pix_x,
   input  logic [$clog2(HEIGHT)-1:0] pix_y,
   input  logic                      pix_on,
   input  logic                      frame_done,
   output logic                      row_valid,
   input  logic                      row_ready,
   output logic [WIDTH-1:0]          row_data,
   output logic [$clog2(HEIGHT)-1:0] row_idx,
   output logic                      frame_out_done,
   output logic                      busy,
   output logic                      drop_err,
   input  logic                      err_clr
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
   state_t state, next;
   logic [HEIGHT-1:0][WIDTH-1:0] fb;
   logic start_pending, xfer, last, in_range, clr, wr, drop;
   always_comb begin
      xfer = row_valid & row_ready;
      last = xfer && row_idx == YW'(HEIGHT - 1);
      in_range = {1'b0, pix_x} < (XW + 1)'(WIDTH) && {1'b0, pix_y} < (YW + 1)'(HEIGHT);
      // a frame_start seen during drain (pending or on the exit cycle) restarts capture
      clr = (frame_start && state != DRAIN) || (last && (start_pending || frame_start));
      wr = state == CAPTURE && pix_valid && in_range && !frame_start;
      drop = state != CAPTURE ? (pix_valid | frame_done)
                              : ((pix_valid && !in_range) || (frame_start && frame_done));
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = frame_start ? CAPTURE : IDLE;
         CAPTURE: next = frame_start ? CAPTURE : frame_done ? DRAIN : CAPTURE;
         DRAIN:   next = !last ? DRAIN : (start_pending || frame_start) ? CAPTURE : IDLE;
         default: next = IDLE;
      endcase
   end
   always_comb begin
      row_valid = state == DRAIN;
      busy = state != IDLE;
      row_data = row_valid ? fb[row_idx] : '0;
      frame_out_done = last;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fb <= '0;
         start_pending <= 1'b0;
         row_idx <= '0;
         drop_err <= 1'b0;
      end else begin
         if (clr) fb <= '0;
         else if (wr) fb[pix_y][pix_x] <= BLEND_OR ? (fb[pix_y][pix_x] | pix_on) : pix_on;
         start_pending <= state == DRAIN && !last && (start_pending || frame_start);
         row_idx <= last ? '0 : xfer ? row_idx + YW'(1) : row_idx;
         drop_err <= drop | (drop_err & ~err_clr);
      end
endmodule

// File: tb/tb_raster_fb_capture.sv
// tb_raster_fb_capture: directed checks of capture, blend modes, backpressure,
// simultaneous events, discards and reset during drain.
module tb_raster_fb_capture;
   logic clk = 0, rst = 0, frame_start = 0, pix_valid = 0, pix_on = 0, frame_done = 0;
   logic row_ready = 0, err_clr = 0;
   logic [2:0] pix_x = 0, pix_y = 0;
   logic rv1, rv0, fod1, fod0, busy1, busy0, de1, de0;
   logic [7:0] rd1, rd0;
   logic [2:0] ri1, ri0;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   raster_fb_capture #(.WIDTH(8), .HEIGHT(8), .BLEND_OR(1'b1)) u1 (
      .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .pix_x(pix_x),
      .pix_y(pix_y), .pix_on(pix_on), .frame_done(frame_done), .row_valid(rv1),
      .row_ready(row_ready), .row_data(rd1), .row_idx(ri1), .frame_out_done(fod1),
      .busy(busy1), .drop_err(de1), .err_clr(err_clr));
   raster_fb_capture #(.WIDTH(8), .HEIGHT(8), .BLEND_OR(1'b0)) u0 (
      .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .pix_x(pix_x),
      .pix_y(pix_y), .pix_on(pix_on), .frame_done(frame_done), .row_valid(rv0),
      .row_ready(row_ready), .row_data(rd0), .row_idx(ri0), .frame_out_done(fod0),
      .busy(busy0), .drop_err(de0), .err_clr(err_clr));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic start();
      frame_start = 1;
      step();
      frame_start = 0;
   endtask
   task automatic done();
      frame_done = 1;
      step();
      frame_done = 0;
   endtask
   task automatic pix(input int x, input int y, input bit on);
      pix_valid = 1;
      pix_x = 3'(x);
      pix_y = 3'(y);
      pix_on = on;
      step();
      pix_valid = 0;
   endtask
   // img packs row y in bits [8y+7:8y]; bp applies the 1,0,0 ready pattern
   task automatic drain(input logic [63:0] img1, input logic [63:0] img0, input bit bp,
                        input int min_cyc);
      int cnt = 0, cyc = 0;
      while (cnt < 8 && cyc < 40) begin
         row_ready = bp ? (cyc % 3 == 0) : 1'b1;
         #1;
         chk("row_valid", rv1, 1);
         chk("row_idx", ri1, cnt);
         chk("row_data_or", rd1, img1[cnt*8 +: 8]);
         chk("row_data_ovr", rd0, img0[cnt*8 +: 8]);
         chk("frame_out_done", fod1, row_ready && cnt == 7);
         if (row_ready) cnt++;
         cyc++;
         step();
      end
      chk("drain_transfers", cnt, 8);
      chk("drain_cycles", cyc, min_cyc);
      row_ready = 0;
      #1;
      chk("row_valid_after", rv1, 0);
      chk("row_idx_after", ri1, 0);
   endtask
   initial begin
      rst = 1;
      #1;
      chk("rst_row_valid", rv1, 0);
      chk("rst_row_data", rd1, 0);
      chk("rst_row_idx", ri1, 0);
      chk("rst_fod", fod1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_drop_err", de1, 0);
      step();
      rst = 0;
      step();
      // basic frame
      start();
      chk("busy_capture", busy1, 1);
      chk("capture_no_valid", rv1, 0);
      pix(0, 0, 1);
      pix(7, 7, 1);
      pix(3, 2, 1);
      done();
      drain(64'h8000_0000_0008_0001, 64'h8000_0000_0008_0001, 0, 8);
      chk("busy_idle", busy1, 0);
      chk("no_drop_yet", de1, 0);
      // blend vs overwrite, with backpressure
      start();
      pix(2, 1, 1);
      pix(2, 1, 0);
      done();
      drain(64'h0000_0000_0000_0400, 64'h0, 1, 22);
      // pixel coincident with frame_done
      start();
      pix_valid = 1;
      pix_x = 5;
      pix_y = 4;
      pix_on = 1;
      frame_done = 1;
      step();
      pix_valid = 0;
      frame_done = 0;
      drain(64'h0000_0020_0000_0000, 64'h0000_0020_0000_0000, 0, 8);
      chk("no_drop_simul_pix", de1, 0);
      // frame_start wins over frame_done
      start();
      pix(1, 1, 1);
      frame_start = 1;
      frame_done = 1;
      step();
      frame_start = 0;
      frame_done = 0;
      chk("start_win_busy", busy1, 1);
      chk("start_win_no_drain", rv1, 0);
      chk("start_win_drop", de1, 1);
      err_clr = 1;
      step();
      err_clr = 0;
      chk("err_clr", de1, 0);
      done();
      drain(64'h0, 64'h0, 0, 8);
      // discards and frame_start collapse during drain
      start();
      pix(6, 0, 1);
      done();
      row_ready = 0;
      start();
      start();
      pix_valid = 1;
      pix_x = 0;
      pix_y = 3;
      pix_on = 1;
      err_clr = 1;
      step();
      pix_valid = 0;
      err_clr = 0;
      chk("drop_set_dominant", de1, 1);
      chk("stall_idx", ri1, 0);
      drain(64'h0000_0000_0000_0040, 64'h0000_0000_0000_0040, 0, 8);
      chk("pending_busy", busy1, 1);
      done();
      drain(64'h0, 64'h0, 0, 8);
      chk("single_restart_idle", busy1, 0);
      // discard in IDLE
      err_clr = 1;
      step();
      err_clr = 0;
      chk("err_clr2", de1, 0);
      pix(4, 4, 1);
      chk("idle_drop", de1, 1);
      chk("idle_busy", busy1, 0);
      // reset mid-drain
      start();
      pix(0, 5, 1);
      done();
      row_ready = 1;
      repeat (4) step();
      chk("mid_idx", ri1, 4);
      row_ready = 0;
      rst = 1;
      #1;
      chk("rst_mid_valid", rv1, 0);
      chk("rst_mid_idx", ri1, 0);
      chk("rst_mid_fod", fod1, 0);
      chk("rst_mid_busy", busy1, 0);
      step();
      rst = 0;
      start();
      done();
      drain(64'h0, 64'h0, 0, 8);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/raster_fb_capture.md
Name: raster_fb_capture

Overview:
- Sink-side companion to the 8x8 rasterizer core: consumes its pixel-write stream and assembles a WIDTH x HEIGHT 1-bit framebuffer.
- Once the frame completes, streams the framebuffer out one row per transfer over a valid/ready interface.
- Used by the host-side readout path and by the verification harness to reconstruct rendered frames.

Parameters:
WIDTH, 8, pixels per row; also the row_data width.
HEIGHT, 8, rows per frame.
BLEND_OR, 1, 1: pixel write ORs pix_on into the stored bit; 0: pixel write overwrites the stored bit.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
frame_start  in  1  single-cycle pulse: clear framebuffer, begin capture
pix_valid  in  1  pixel write strobe
pix_x  in  $clog2(WIDTH)  pixel column
pix_y  in  $clog2(HEIGHT)  pixel row
pix_on  in  1  pixel value
frame_done  in  1  single-cycle pulse: frame complete, begin drain
row_valid  out  1  row_data/row_idx valid
row_ready  in  1  downstream accepts row
row_data  out  WIDTH  framebuffer row; bit i = column i
row_idx  out  $clog2(HEIGHT)  index of the row presented
frame_out_done  out  1  one-cycle pulse on the last row transfer
busy  out  1  high in CAPTURE or DRAIN
drop_err  out  1  sticky: input event discarded
err_clr  in  1  clears drop_err

Behaviour:
- Reset (async, rst=1):
  - State IDLE; framebuffer all zeros; start_pending=0.
  - Outputs: row_valid=0, row_data=0, row_idx=0, frame_out_done=0, busy=0, drop_err=0.
- IDLE:
  - frame_start clears all framebuffer bits; state is CAPTURE on the next cycle.
  - pix_valid or frame_done is discarded and sets drop_err.
- CAPTURE:
  - Pixel write on pix_valid: fb[pix_y][pix_x] <= BLEND_OR ? (old | pix_on) : pix_on. Visible to the drain from the next cycle.
  - Coordinates with pix_x>=WIDTH or pix_y>=HEIGHT: write suppressed, drop_err set.
  - frame_done: state is DRAIN next cycle, with row_idx=0 and row_valid=1 one cycle after frame_done is sampled.
  - pix_valid and frame_done in the same cycle: the pixel is written first and is included in the drain.
  - frame_start: restarts the capture (framebuffer cleared, remains in CAPTURE). If frame_done arrives in the same cycle, frame_start wins and frame_done is dropped, setting drop_err.
- DRAIN:
  - row_valid=1; row_data=fb[row_idx].
  - row_data and row_idx are held stable while row_valid & !row_ready.
  - A transfer (row_valid & row_ready) advances row_idx by 1.
  - The transfer at row_idx=HEIGHT-1 pulses frame_out_done in that same cycle. Next cycle: row_valid=0, row_idx=0, and state is IDLE, or CAPTURE if start_pending.
  - pix_valid and frame_done are discarded and set drop_err.
  - frame_start sets start_pending; multiple pulses collapse into one.
  - When start_pending is consumed at drain exit, the framebuffer is cleared in that transition cycle and start_pending returns to 0.
- Minimum drain latency: HEIGHT cycles with row_ready held high.
- The framebuffer is not modified during DRAIN.
- drop_err: set-dominant; if a set and err_clr occur in the same cycle, drop_err=1.
- busy = (state != IDLE).
- Reset mid-drain: the output stream aborts immediately; no frame_out_done is issued.

Test Plan:
- Reset then frame_start; write (0,0),(7,7),(3,2) on; frame_done; row_ready=1 -> rows 0..7 = 0x01,0,0x08,0,0,0,0,0x80 on consecutive cycles; frame_out_done coincident with row 7; busy drops the next cycle.
- BLEND_OR=1: write (2,1) on, then (2,1) off -> row1=0x04. BLEND_OR=0: same sequence -> row1=0x00.
- Backpressure: toggle row_ready 1,0,0,1,... during drain -> row_data/row_idx held stable on stalled cycles; exactly 8 transfers, in order 0..7.
- Simultaneous events:
  - pix_valid(5,4,on) with frame_done -> row4=0x20.
  - frame_start with frame_done -> framebuffer cleared, state stays CAPTURE, drop_err=1.
- Discards: frame_start during drain -> after row 7, framebuffer=0 and busy stays 1 in CAPTURE. pix_valid in IDLE or DRAIN -> drop_err=1, framebuffer unchanged; err_clr -> drop_err=0.
- rst asserted after row 3 transfer -> row_valid=0 and row_idx=0 immediately; all framebuffer rows read 0 after the next capture with no writes.
